// File: rtl/mod_counter.sv
// Modulo-(limit+1) up/down counter with parallel load, terminal-count pulse and sticky overflow.
// Define MOD_COUNTER_SAT_EN to make the counter saturate at its bounds instead of wrapping.
module mod_counter #(
    parameter int          WIDTH     = 8,
    parameter int unsigned RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic [WIDTH-1:0] limit,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] RST_CNT = WIDTH'(RESET_VAL);

    logic [WIDTH:0]   step;
    logic [WIDTH-1:0] load_val;
    logic             ovf_set;

    // A load value above the terminal value is clamped so count never leaves 0..limit.
    function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] d,
                                                    input logic [WIDTH-1:0] lim);
        clamp_load = (d > lim) ? lim : d;
    endfunction

    // Returns {hit, next}; hit drives tc and sets the sticky flag.
    function automatic logic [WIDTH:0] count_up(input logic [WIDTH-1:0] c,
                                                input logic [WIDTH-1:0] lim);
        logic [WIDTH-1:0] n;
        logic             hit;
`ifdef MOD_COUNTER_SAT_EN
        if (c < lim) begin
            n   = c + WIDTH'(1);
            hit = (n == lim);
        end else begin
            n   = lim;
            hit = 1'b1;
        end
`else
        if (c < lim) begin
            n   = c + WIDTH'(1);
            hit = 1'b0;
        end else begin
            n   = '0;
            hit = 1'b1;
        end
`endif
        count_up = {hit, n};
    endfunction

    // A count left above a lowered limit snaps back to limit without counting as a wrap.
    function automatic logic [WIDTH:0] count_dn(input logic [WIDTH-1:0] c,
                                                input logic [WIDTH-1:0] lim);
        logic [WIDTH-1:0] n;
        logic             hit;
        if (c > lim) begin
            n   = lim;
            hit = 1'b0;
        end else if (c == '0) begin
`ifdef MOD_COUNTER_SAT_EN
            n   = '0;
`else
            n   = lim;
`endif
            hit = 1'b1;
        end else begin
            n = c - WIDTH'(1);
`ifdef MOD_COUNTER_SAT_EN
            hit = (n == '0);
`else
            hit = 1'b0;
`endif
        end
        count_dn = {hit, n};
    endfunction

    always_comb begin
        step     = up ? count_up(count, limit) : count_dn(count, limit);
        load_val = clamp_load(din, limit);
        ovf_set  = !load && en && step[WIDTH];
    end

    // Output register stage: single-cycle latency, load beats enable.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= RST_CNT;
            tc    <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            if (load) begin
                count <= load_val;
                tc    <= 1'b0;
            end else if (en) begin
                count <= step[WIDTH-1:0];
                tc    <= step[WIDTH];
            end else begin
                tc    <= 1'b0;
            end
            ovf <= ovf_set | (ovf & ~clr_ovf);
        end
    end

endmodule

// File: tb/tb_mod_counter.sv
// Testbench for mod_counter: directed vector table, hand-written corner sequences and a
// randomized run against an arithmetic reference model (two instances, RESET_VAL 0 and 5).
module tb_mod_counter;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         en = 1'b0;
    logic         up = 1'b1;
    logic         load = 1'b0;
    logic [W-1:0] din = '0;
    logic [W-1:0] limit = 4'd9;
    logic         clr_ovf = 1'b0;
    logic [W-1:0] count0, count5;
    logic         tc0, tc5, ovf0, ovf5;

    int n_checks = 0;
    int n_fail   = 0;

    mod_counter #(.WIDTH(W), .RESET_VAL(0)) u_dut0 (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .din(din),
        .limit(limit), .clr_ovf(clr_ovf), .count(count0), .tc(tc0), .ovf(ovf0)
    );

    mod_counter #(.WIDTH(W), .RESET_VAL(5)) u_dut5 (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .din(din),
        .limit(limit), .clr_ovf(clr_ovf), .count(count5), .tc(tc5), .ovf(ovf5)
    );

    always #5 clk = ~clk;

    typedef struct {
        int count;
        bit tc;
        bit ovf;
    } mstate_t;

    typedef struct {
        string name;
        bit    rst, load, en, up, clr;
        int    din, limit;
        int    ec;
        bit    etc, eovf;
    } vec_t;

    vec_t    vecs[$];
    mstate_t m0, m5;

    // Reference model: plain integer arithmetic on the counting rules.
    function automatic mstate_t model_step(mstate_t s, bit r, bit ld, bit e, bit u, bit cl,
                                           int d, int lim, int rv);
        mstate_t n;
        bit      hit;
        if (!r) begin
            n.count = rv; n.tc = 0; n.ovf = 0;
            return n;
        end
        n   = s;
        hit = 0;
        if (ld) begin
            n.count = (d > lim) ? lim : d;
        end else if (e) begin
`ifdef MOD_COUNTER_SAT_EN
            if (u) begin
                n.count = (s.count + 1 < lim) ? s.count + 1 : lim;
                hit     = (n.count == lim);
            end else if (s.count > lim) begin
                n.count = lim;
            end else begin
                n.count = (s.count > 0) ? s.count - 1 : 0;
                hit     = (n.count == 0);
            end
`else
            if (u) begin
                n.count = (s.count <= lim) ? (s.count + 1) % (lim + 1) : 0;
                hit     = (n.count == 0);
            end else if (s.count > lim) begin
                n.count = lim;
            end else begin
                n.count = (s.count + lim) % (lim + 1);
                hit     = (s.count == 0);
            end
`endif
        end
        n.tc  = hit;
        n.ovf = hit ? 1'b1 : (cl ? 1'b0 : s.ovf);
        return n;
    endfunction

    task automatic check(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(bit r, bit ld, bit e, bit u, bit cl, int d, int lim);
        rst = r; load = ld; en = e; up = u; clr_ovf = cl;
        din = W'(d); limit = W'(lim);
        @(posedge clk);
        m0 = model_step(m0, r, ld, e, u, cl, d, lim, 0);
        m5 = model_step(m5, r, ld, e, u, cl, d, lim, 5);
        #1;
    endtask

    task automatic check_models(string tag);
        check({tag, ".count0"}, int'(count0), m0.count);
        check({tag, ".tc0"},    int'(tc0),    int'(m0.tc));
        check({tag, ".ovf0"},   int'(ovf0),   int'(m0.ovf));
        check({tag, ".count5"}, int'(count5), m5.count);
        check({tag, ".tc5"},    int'(tc5),    int'(m5.tc));
        check({tag, ".ovf5"},   int'(ovf5),   int'(m5.ovf));
    endtask

    function automatic void add(string nm, bit r, bit ld, bit e, bit u, bit cl, int d, int lim,
                                int ec, bit etc, bit eovf);
        vec_t v;
        v.name = nm; v.rst = r; v.load = ld; v.en = e; v.up = u; v.clr = cl;
        v.din = d; v.limit = lim; v.ec = ec; v.etc = etc; v.eovf = eovf;
        vecs.push_back(v);
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        m0 = '{0, 0, 0};
        m5 = '{0, 0, 0};

        //               name       rst ld en up clr din lim  count tc ovf
        add("reset",      0, 1, 1, 1, 0, 7,  9,   0,    0, 0);
`ifdef MOD_COUNTER_SAT_EN
        add("ld8",        1, 1, 0, 1, 0, 8,  9,   8,    0, 0);
        for (int i = 0; i < 3; i++)
            add("sat_up",  1, 0, 1, 1, 0, 0,  9,   9,    1, 1);
        add("sat_upclr",  1, 0, 1, 1, 1, 0,  9,   9,    1, 1);
        add("clr",        1, 0, 0, 1, 1, 0,  9,   9,    0, 0);
        add("ldclamp",    1, 1, 0, 1, 0, 12, 9,   9,    0, 0);
        add("ldwins",     1, 1, 1, 1, 0, 3,  9,   3,    0, 0);
        add("ld1",        1, 1, 0, 0, 0, 1,  9,   1,    0, 0);
        add("sat_dn",     1, 0, 1, 0, 0, 0,  9,   0,    1, 1);
        add("sat_dn0",    1, 0, 1, 0, 0, 0,  9,   0,    1, 1);
        add("clr",        1, 0, 0, 1, 1, 0,  9,   0,    0, 0);
        add("ld8",        1, 1, 0, 1, 0, 8,  9,   8,    0, 0);
        add("dnover",     1, 0, 1, 0, 0, 0,  5,   5,    0, 0);
        add("ld8",        1, 1, 0, 1, 0, 8,  9,   8,    0, 0);
        add("upover",     1, 0, 1, 1, 0, 0,  5,   5,    1, 1);
        add("lim0up",     1, 0, 1, 1, 0, 0,  0,   0,    1, 1);
        add("lim0dn",     1, 0, 1, 0, 0, 0,  0,   0,    1, 1);
`else
        for (int i = 1; i <= 12; i++)
            add("up9",     1, 0, 1, 1, 0, 0,  9,   (i <= 9) ? i : i - 10, i == 10, i >= 10);
        add("clr",        1, 0, 0, 1, 1, 0,  9,   2,    0, 0);
        add("ld0",        1, 1, 0, 0, 0, 0,  9,   0,    0, 0);
        add("dn9",        1, 0, 1, 0, 0, 0,  9,   9,    1, 1);
        add("dn8",        1, 0, 1, 0, 0, 0,  9,   8,    0, 1);
        add("dn7",        1, 0, 1, 0, 0, 0,  9,   7,    0, 1);
        add("ldclamp",    1, 1, 0, 1, 0, 12, 9,   9,    0, 1);
        add("ldwins",     1, 1, 1, 1, 0, 3,  9,   3,    0, 1);
        add("ld9",        1, 1, 0, 1, 0, 9,  9,   9,    0, 1);
        add("clr",        1, 0, 0, 1, 1, 0,  9,   9,    0, 0);
        add("wrapclr",    1, 0, 1, 1, 1, 0,  9,   0,    1, 1);
        add("clr",        1, 0, 0, 1, 1, 0,  9,   0,    0, 0);
        add("ld8",        1, 1, 0, 1, 0, 8,  9,   8,    0, 0);
        add("dnover",     1, 0, 1, 0, 0, 0,  5,   5,    0, 0);
        add("ld8",        1, 1, 0, 1, 0, 8,  9,   8,    0, 0);
        add("upover",     1, 0, 1, 1, 0, 0,  5,   0,    1, 1);
        add("lim0up",     1, 0, 1, 1, 0, 0,  0,   0,    1, 1);
        add("lim0up",     1, 0, 1, 1, 0, 0,  0,   0,    1, 1);
        add("lim0dn",     1, 0, 1, 0, 0, 0,  0,   0,    1, 1);
`endif
        add("hold",       1, 0, 0, 1, 0, 0,  9,   0,    0, 1);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].load, vecs[i].en, vecs[i].up, vecs[i].clr,
                  vecs[i].din, vecs[i].limit);
            check({vecs[i].name, ".count"}, int'(count0), vecs[i].ec);
            check({vecs[i].name, ".tc"},    int'(tc0),    int'(vecs[i].etc));
            check({vecs[i].name, ".ovf"},   int'(ovf0),   int'(vecs[i].eovf));
            check({vecs[i].name, ".count5"}, int'(count5), m5.count);
        end

        // Reset mid-operation with load and enable active, then resume.
        drive(1, 1, 0, 1, 0, 7, 9);
        drive(1, 0, 1, 1, 0, 0, 9);
        drive(0, 1, 1, 1, 0, 3, 9);
        check("rst_mid.count5", int'(count5), 5);
        check("rst_mid.tc5",    int'(tc5),    0);
        check("rst_mid.ovf5",   int'(ovf5),   0);
        check("rst_mid.count0", int'(count0), 0);
        drive(1, 0, 1, 1, 0, 0, 9);
        check("rst_resume.count5", int'(count5), 6);
        check("rst_resume.count0", int'(count0), 1);

        // Inputs changing between edges must not reach the outputs.
        load = 1'b1; din = 4'd3; rst = 1'b1; en = 1'b1;
        #2;
        check("no_comb.count0", int'(count0), 1);
        check("no_comb.tc0",    int'(tc0),    0);

        for (int i = 0; i < 2000; i++) begin
            bit r, ld, e, u, cl;
            int d, lim;
            r   = ($urandom_range(0, 31) != 0);
            ld  = ($urandom_range(0, 7) == 0);
            e   = ($urandom_range(0, 3) != 0);
            u   = $urandom_range(0, 1);
            cl  = ($urandom_range(0, 15) == 0);
            d   = $urandom_range(0, 15);
            case ($urandom_range(0, 7))
                0:       lim = 0;
                1:       lim = 1;
                2, 3:    lim = 9;
                4:       lim = 15;
                default: lim = $urandom_range(0, 15);
            endcase
            drive(r, ld, e, u, cl, d, lim);
            check_models("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mod_counter.md
MOD_COUNTER -- requirements
Module: mod_counter

Interface
REQ-001 The module SHALL have the parameter WIDTH, default 8, giving the counter width in bits (legal range 2..32).
REQ-002 The module SHALL have the parameter RESET_VAL, default 0, giving the count value loaded by reset (must be ≤ 2^WIDTH-1).
REQ-003 The module SHALL have the port clk, input, 1 bit: the single clock, with all state updating on its rising edge.
REQ-004 The module SHALL have the port rst, input, 1 bit: reset, synchronous and active-low.
REQ-005 The module SHALL have the port en, input, 1 bit: count enable.
REQ-006 The module SHALL have the port up, input, 1 bit: direction, where 1 counts up and 0 counts down.
REQ-007 The module SHALL have the port load, input, 1 bit: synchronous parallel load strobe.
REQ-008 The module SHALL have the port din, input, WIDTH bits: the parallel load value.
REQ-009 The module SHALL have the port limit, input, WIDTH bits: the terminal value, so that the count range is 0..limit (modulus limit+1).
REQ-010 The module SHALL have the port clr_ovf, input, 1 bit: clears the sticky overflow flag.
REQ-011 The module SHALL have the port count, output, WIDTH bits: the registered count value.
REQ-012 The module SHALL have the port tc, output, 1 bit: registered terminal-count pulse.
REQ-013 The module SHALL have the port ovf, output, 1 bit: registered sticky wrap/overflow flag.

Function
REQ-014 The module SHALL register all outputs, with count, tc and ovf changing only on the rising edge of clk.
REQ-015 The module SHALL give update priority per edge in the order rst low, then load, then en, then hold.
REQ-016 On load, the module SHALL set count to din when din ≤ limit and to limit otherwise; tc SHALL be 0 and ovf SHALL be unaffected.
REQ-017 With en=1, up=1 and count < limit, the module SHALL set count to count+1 and tc to 0.
REQ-018 With en=1, up=1 and count ≥ limit, the module SHALL set count to 0 (wrap) and tc to 1, and SHALL set ovf.
REQ-019 With en=1, up=0 and 0 < count ≤ limit, the module SHALL set count to count-1 and tc to 0.
REQ-020 With en=1, up=0 and count = 0, the module SHALL set count to limit (wrap) and tc to 1, and SHALL set ovf.
REQ-021 With en=1, up=0 and count > limit (limit lowered mid-run), the module SHALL set count to limit with tc=0 and ovf unchanged.
REQ-022 When en=0 and load=0, the module SHALL hold count and set tc to 0.
REQ-023 The module SHALL assert tc for exactly the one cycle in which the wrapped value first appears on count.
REQ-024 When limit=0, the module SHALL keep count at 0 with tc=1 on every enabled cycle.
REQ-025 The module SHALL clear ovf only on clr_ovf=1; when a wrap and clr_ovf=1 coincide, ovf SHALL be set (set wins).
REQ-026 The module SHALL produce arithmetic results of exactly WIDTH bits, and no intermediate result SHALL exceed WIDTH+1 bits.
REQ-027 The module SHALL have a latency of one cycle from sampled inputs to updated outputs, with no combinational input-to-output path.

Reset
REQ-028 On a rising edge of clk with rst=0, the module SHALL set count to RESET_VAL, tc to 0 and ovf to 0, regardless of all other inputs.
REQ-029 The module SHALL cancel any load or count in progress when reset is asserted mid-operation, and SHALL resume normal operation on the first edge with rst=1.

Configuration
REQ-030 When macro MOD_COUNTER_SAT_EN is defined, the module SHALL saturate instead of wrapping: up at count ≥ limit holds (or clamps to) limit, and down at count = 0 holds 0.
REQ-031 With MOD_COUNTER_SAT_EN defined, the module SHALL assert tc on each enabled cycle spent at the bound and SHALL set ovf on the first such cycle.
REQ-032 Without MOD_COUNTER_SAT_EN, the module SHALL exhibit the wrap behaviour of REQ-018 and REQ-020.

Verification
REQ-033 The bench SHALL cover: WIDTH=4, limit=9, up=1, en=1 for 12 cycles from reset -> count 1..9,0,1,2; tc=1 only on the cycle count becomes 0; ovf=1 from then on.
REQ-034 The bench SHALL cover: up=0, en=1 from count=0 with limit=9 -> count 9,8,7; tc=1 on the 9 cycle; ovf set.
REQ-035 The bench SHALL cover: load=1, din=12, limit=9 -> count=9; then load=1 with en=1, din=3 -> count=3 (load beats en).
REQ-036 The bench SHALL cover: wrap and clr_ovf=1 on the same edge -> ovf=1; next cycle clr_ovf=1 alone -> ovf=0.
REQ-037 The bench SHALL cover: rst=0 asserted while en=1 and load=1 with RESET_VAL=5 -> count=5, tc=0, ovf=0 on that edge.
REQ-038 The bench SHALL cover, with MOD_COUNTER_SAT_EN defined: limit=9, count up from 8 -> 9,9,9; tc=1 on each 9 cycle; ovf=1.
